// File: rtl/ps2_receiver.sv
// PS/2 device-to-host frame receiver: filters ps2_clk, samples ps2_data on
// filtered falling edges and emits one checked byte per 11-bit frame.
module ps2_receiver #(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 10000,
  parameter int TO_W       = 14
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_en,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] dout,
  output logic       rx_done_tick,
  output logic       parity_err,
  output logic       frame_err,
  output logic       timeout_tick,
  output logic       rx_idle
);

  typedef enum logic [1:0] {IDLE, RECV, DONE} state_t;

  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT);
  localparam logic [TO_W-1:0] TO_ONE = TO_W'(1);

  state_t                state, state_n;
  logic                  data_s1, data_sync;
  logic [FILTER_LEN-1:0] filt_reg;
  logic                  fclk, fclk_n, fall_edge;
  logic [9:0]            shift, shift_n;
  logic [3:0]            bit_cnt, bit_cnt_n;
  logic [TO_W-1:0]       to_cnt, to_cnt_n;
  logic [7:0]            dout_n;
  logic                  perr_n, ferr_n, done_n, tot_n;

  // Filtered clock only moves on a full window of agreeing samples, so short
  // glitches on the open-collector line never create an edge.
  always_comb begin
    fclk_n = fclk;
    if (&filt_reg)
      fclk_n = 1'b1;
    else if (~|filt_reg)
      fclk_n = 1'b0;
  end

  assign fall_edge = fclk & ~fclk_n;
  assign rx_idle   = (state == IDLE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      data_s1      <= 1'b0;
      data_sync    <= 1'b0;
      filt_reg     <= '0;
      fclk         <= 1'b0;
      shift        <= '0;
      bit_cnt      <= '0;
      to_cnt       <= '0;
      dout         <= 8'h00;
      parity_err   <= 1'b0;
      frame_err    <= 1'b0;
      rx_done_tick <= 1'b0;
      timeout_tick <= 1'b0;
    end else begin
      state        <= state_n;
      data_s1      <= ps2_data;
      data_sync    <= data_s1;
      filt_reg     <= {filt_reg[FILTER_LEN-2:0], ps2_clk};
      fclk         <= fclk_n;
      shift        <= shift_n;
      bit_cnt      <= bit_cnt_n;
      to_cnt       <= to_cnt_n;
      dout         <= dout_n;
      parity_err   <= perr_n;
      frame_err    <= ferr_n;
      rx_done_tick <= done_n;
      timeout_tick <= tot_n;
    end
  end

  always_comb begin
    state_n   = state;
    shift_n   = shift;
    bit_cnt_n = bit_cnt;
    to_cnt_n  = to_cnt;
    dout_n    = dout;
    perr_n    = parity_err;
    ferr_n    = frame_err;
    done_n    = 1'b0;
    tot_n     = 1'b0;
    case (state)
      IDLE: begin
        if (rx_en && fall_edge && !data_sync) begin
          bit_cnt_n = 4'd9;
          to_cnt_n  = '0;
          state_n   = RECV;
        end
      end
      RECV: begin
        // Losing rx_en means the host owns the bus; drop the frame silently.
        if (!rx_en) begin
          state_n = IDLE;
        end else if (fall_edge) begin
          shift_n  = {data_sync, shift[9:1]};
          to_cnt_n = '0;
          if (bit_cnt == 4'd0)
            state_n = DONE;
          else
            bit_cnt_n = bit_cnt - 4'd1;
        end else if (to_cnt == TO_MAX) begin
          tot_n   = 1'b1;
          state_n = IDLE;
        end else begin
          to_cnt_n = to_cnt + TO_ONE;
        end
      end
      DONE: begin
        dout_n  = shift[7:0];
        perr_n  = ~(^shift[8:0]);
        ferr_n  = ~shift[9];
        done_n  = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ps2_receiver.sv
// Directed bench for ps2_receiver: good/bad frames, timeout, rx_en gating,
// clock glitches and mid-frame reset, with hand-computed expectations.
module tb_ps2_receiver;
  localparam int TIMEOUT = 200;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx_en = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] dout;
  logic       rx_done_tick, parity_err, frame_err, timeout_tick, rx_idle;

  int checks = 0, errors = 0;
  int cyc = 0, done_cnt = 0, to_cnt = 0, busy_cnt = 0, done_cyc = 0, fall_cyc = 0;

  ps2_receiver #(.FILTER_LEN(8), .TIMEOUT(TIMEOUT), .TO_W(8)) dut (
    .clk(clk), .rst(rst), .rx_en(rx_en), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .dout(dout), .rx_done_tick(rx_done_tick), .parity_err(parity_err),
    .frame_err(frame_err), .timeout_tick(timeout_tick), .rx_idle(rx_idle)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_done_tick) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (timeout_tick) to_cnt++;
    if (!rx_idle) busy_cnt++;
  end

  // Sends the first nbits bits of {stop, par, d, start=0}; 40-cycle ps2 period.
  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop,
                            input int nbits, input bit glitch);
    logic [10:0] bits;
    bits = {stop, par, d, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = bits[i];
      repeat (5) @(negedge clk);
      if (glitch) begin
        ps2_clk = 1'b0;
        repeat (3) @(negedge clk);
        ps2_clk = 1'b1;
      end else begin
        repeat (3) @(negedge clk);
      end
      repeat (12) @(negedge clk);
      ps2_clk  = 1'b0;
      fall_cyc = cyc;
      if (glitch) begin
        repeat (8) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (3) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (9) @(negedge clk);
      end else begin
        repeat (20) @(negedge clk);
      end
      ps2_clk = 1'b1;
    end
    repeat (20) @(negedge clk);
  endtask

  task automatic check_byte(input string name, input logic [7:0] d, input logic pe,
                            input logic fe, input int d0);
    checks++;
    if (done_cnt - d0 !== 1) begin
      errors++; $display("FAIL %s ticks: got %0d want 1", name, done_cnt - d0);
    end
    checks++;
    if (dout !== d) begin
      errors++; $display("FAIL %s dout: got %h want %h", name, dout, d);
    end
    checks++;
    if (parity_err !== pe) begin
      errors++; $display("FAIL %s parity_err: got %b want %b", name, parity_err, pe);
    end
    checks++;
    if (frame_err !== fe) begin
      errors++; $display("FAIL %s frame_err: got %b want %b", name, frame_err, fe);
    end
  endtask

  task automatic check_reset_outs(input string name);
    checks++;
    if ({dout, rx_done_tick, parity_err, frame_err, timeout_tick, rx_idle} !== 13'b0000_0000_0000_1) begin
      errors++;
      $display("FAIL %s outputs: got dout=%h done=%b pe=%b fe=%b to=%b idle=%b want 00/0/0/0/0/1",
               name, dout, rx_done_tick, parity_err, frame_err, timeout_tick, rx_idle);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outs("reset");
    rst = 1'b1;
    rx_en = 1'b1;
    repeat (20) @(negedge clk);
    checks++;
    if (rx_idle !== 1'b1) begin
      errors++; $display("FAIL reset_idle: got %b want 1", rx_idle);
    end
  endtask

  task automatic test_ack();
    int d0 = done_cnt;
    send_frame(8'hFA, 1'b1, 1'b1, 11, 1'b0);
    check_byte("ack_fa", 8'hFA, 1'b0, 1'b0, d0);
    // 8 filter samples + 1 DONE cycle + registered tick
    checks++;
    if (done_cyc - fall_cyc !== 10) begin
      errors++; $display("FAIL ack_latency: got %0d want 10", done_cyc - fall_cyc);
    end
  endtask

  task automatic test_errors();
    int d0 = done_cnt;
    send_frame(8'hF4, 1'b1, 1'b1, 11, 1'b0);
    check_byte("parity_f4", 8'hF4, 1'b1, 1'b0, d0);
    d0 = done_cnt;
    send_frame(8'h55, 1'b1, 1'b0, 11, 1'b0);
    check_byte("stop_55", 8'h55, 1'b0, 1'b1, d0);
  endtask

  task automatic test_timeout();
    int d0 = done_cnt;
    int t0 = to_cnt;
    send_frame(8'h3C, 1'b1, 1'b1, 5, 1'b0);
    checks++;
    if (rx_idle !== 1'b0) begin
      errors++; $display("FAIL timeout_busy: got %b want 0", rx_idle);
    end
    repeat (TIMEOUT + 60) @(negedge clk);
    checks++;
    if (to_cnt - t0 !== 1) begin
      errors++; $display("FAIL timeout_ticks: got %0d want 1", to_cnt - t0);
    end
    checks++;
    if (done_cnt - d0 !== 0) begin
      errors++; $display("FAIL timeout_done: got %0d want 0", done_cnt - d0);
    end
    checks++;
    if (dout !== 8'h55 || rx_idle !== 1'b1) begin
      errors++; $display("FAIL timeout_hold: got dout=%h idle=%b want 55/1", dout, rx_idle);
    end
    d0 = done_cnt;
    send_frame(8'h08, 1'b0, 1'b1, 11, 1'b0);
    check_byte("after_to_08", 8'h08, 1'b0, 1'b0, d0);
  endtask

  task automatic test_rx_en();
    int d0 = done_cnt;
    int t0 = to_cnt;
    int b0 = busy_cnt;
    rx_en = 1'b0;
    send_frame(8'hFA, 1'b1, 1'b1, 11, 1'b0);
    repeat (TIMEOUT + 20) @(negedge clk);
    checks++;
    if (done_cnt - d0 !== 0 || to_cnt - t0 !== 0 || busy_cnt - b0 !== 0) begin
      errors++; $display("FAIL rx_en_off: got done=%0d to=%0d busy=%0d want 0/0/0",
                         done_cnt - d0, to_cnt - t0, busy_cnt - b0);
    end
    rx_en = 1'b1;
    send_frame(8'hFA, 1'b1, 1'b1, 6, 1'b0);
    checks++;
    if (rx_idle !== 1'b0) begin
      errors++; $display("FAIL rx_en_mid_busy: got %b want 0", rx_idle);
    end
    rx_en = 1'b0;
    @(negedge clk);
    checks++;
    if (rx_idle !== 1'b1) begin
      errors++; $display("FAIL rx_en_mid_idle: got %b want 1", rx_idle);
    end
    repeat (TIMEOUT + 40) @(negedge clk);
    checks++;
    if (done_cnt - d0 !== 0 || to_cnt - t0 !== 0) begin
      errors++; $display("FAIL rx_en_mid_ticks: got done=%0d to=%0d want 0/0",
                         done_cnt - d0, to_cnt - t0);
    end
    rx_en = 1'b1;
  endtask

  task automatic test_glitch_reset();
    int d0 = done_cnt;
    send_frame(8'hA5, 1'b1, 1'b1, 11, 1'b1);
    check_byte("glitch_a5", 8'hA5, 1'b0, 1'b0, d0);
    send_frame(8'hC3, 1'b1, 1'b1, 5, 1'b1);
    rst = 1'b0;
    @(negedge clk);
    check_reset_outs("mid_reset");
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (rx_idle !== 1'b1) begin
      errors++; $display("FAIL mid_reset_idle: got %b want 1", rx_idle);
    end
    repeat (20) @(negedge clk);
    d0 = done_cnt;
    send_frame(8'h00, 1'b1, 1'b1, 11, 1'b1);
    check_byte("after_rst_00", 8'h00, 1'b0, 1'b0, d0);
  endtask

  initial begin
    test_reset();
    test_ack();
    test_errors();
    test_timeout();
    test_rx_en();
    test_glitch_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ps2_receiver.md
Name: ps2_receiver

Overview:
- Device-to-host PS/2 frame receiver. It sits beside ps2_transmiter on the same ps2_clk/ps2_data pins and consumes what the mouse sends back: the 0xFA ACK after each host command, and the 3-byte movement packets.
- It filters ps2_clk, detects falling edges, deserialises the 11-bit frame (start, 8 data LSB-first, odd parity, stop), checks it and emits one byte per frame to the packet assembler.

Parameters:
- FILTER_LEN, 8: number of consecutive identical ps2_clk samples required to change the filtered clock level.
- TIMEOUT, 10000: clk cycles allowed between falling edges inside a frame before the frame is aborted (200 us at 50 MHz).
- TO_W, 14: width of the timeout counter; must satisfy 2^TO_W > TIMEOUT.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous active-low reset.
- rx_en  input  1  receive enable; tied to transmiter_idle so host transmissions are never decoded.
- ps2_clk  input  1  PS/2 clock pin (read only here).
- ps2_data  input  1  PS/2 data pin (read only here).
- dout  output  8  last received data byte.
- rx_done_tick  output  1  one-cycle pulse: complete frame received; dout, parity_err and frame_err are valid.
- parity_err  output  1  last frame failed the odd-parity check.
- frame_err  output  1  last frame had stop bit = 0.
- timeout_tick  output  1  one-cycle pulse: frame aborted by timeout.
- rx_idle  output  1  high while in IDLE.

Behaviour:
- Reset (rst=0 at a clk edge), also valid mid-frame:
  - state=IDLE; shift register, bit counter and timeout counter = 0; filter register = all 0s; filtered clock = 0.
  - dout=8'h00; rx_done_tick=0; timeout_tick=0; parity_err=0; frame_err=0; rx_idle=1.
- Input conditioning:
  - ps2_data passes through a 2-FF synchroniser.
  - ps2_clk is shifted into a FILTER_LEN-bit register. Filtered clock goes to 1 when the register is all 1s, to 0 when it is all 0s, otherwise holds.
  - fall_edge is a single cycle: filtered clock is currently 1 and its next value is 0.
- States: IDLE, RECV, DONE.
- IDLE:
  - If rx_en=1, fall_edge=1 and synchronised data=0 (start bit): bit_cnt=9, timeout counter=0, go to RECV.
  - A fall_edge with data=1 is ignored; the state stays IDLE.
- RECV:
  - Each fall_edge: shift = {data_sync, shift[9:1]}, timeout counter=0.
  - If bit_cnt==0 on that edge, go to DONE; otherwise bit_cnt decrements.
  - After the 10th shift: shift[7:0]=data, shift[8]=parity, shift[9]=stop.
  - No fall_edge: timeout counter increments. When it reaches TIMEOUT: timeout_tick=1 for one cycle, go to IDLE. dout and the error flags are unchanged.
  - rx_en falling to 0: go to IDLE immediately, no tick, frame discarded. This takes priority over fall_edge in the same cycle.
- DONE (exactly one cycle):
  - Register dout=shift[7:0], parity_err=~(^shift[8:0]), frame_err=~shift[9].
  - rx_done_tick=1 for one cycle, then go to IDLE.
  - Frames with errors still produce rx_done_tick; downstream checks the flags.
- Latency: rx_done_tick rises 2 clk cycles after the cycle in which the stop-bit fall_edge is detected. dout and the flags hold until the next DONE.
- A start bit detected in the cycle immediately after DONE is accepted (no dead time beyond the single DONE cycle).
- rx_idle is combinational from state (state==IDLE).

Test Plan:
- Byte 0xFA, bits 0,1,0,1,1,1,1,1, parity=1, stop=1, clock period 80 us -> one rx_done_tick; dout=8'hFA; parity_err=0; frame_err=0.
- Byte 0xF4 with wrong parity bit 1 -> rx_done_tick; dout=8'hF4; parity_err=1; frame_err=0.
- Byte 0x55 with stop bit 0 -> rx_done_tick; dout=8'h55; frame_err=1.
- Clock stops after 4 data bits for >TIMEOUT cycles -> timeout_tick pulses once; no rx_done_tick; dout keeps its prior value; a following valid 0x08 frame is received correctly.
- rx_en=0 during a full 0xFA frame -> no ticks, rx_idle stays 1. Separately, rx_en dropped mid-frame -> return to IDLE, no ticks.
- 3-cycle ps2_clk glitches between edges, plus rst=0 asserted mid-frame -> glitches produce no extra bits; reset gives all outputs at reset values and IDLE next cycle; the next 0x00 frame is received with parity_err=0.
